tsc_ctrl: RTL

Trigger/capture controller that sequences the external 8-bit ADC through its req/rdy handshake and stores samples in a circular pre-trigger buffer. It raises a trigger when a sample exceeds a programmable threshold, captures a fixed number of post-trigger samples, then streams the whole window out oldest-first. It sits between the top-level TSC logic and the ADC, and owns the ADC's `req` and `rst` lines.

---
 rtl/tsc_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tsc_ctrl.sv
//==========================================================================
// tsc_ctrl: ADC req/rdy sequencer with circular pre-trigger capture buffer
// Revision: 1.0
//==========================================================================
`default_nettype none

module tsc_ctrl #(
  parameter int DEPTH = 16,
  parameter int POST  = 4,
  parameter int TMO   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [7:0]               trd_i,
  output logic                     adc_req_o,
  output logic                     adc_rst_o,
  input  logic                     adc_rdy_i,
  input  logic [7:0]               adc_dat_i,
  input  logic                     rd_i,
  output logic [7:0]               sd_o,
  output logic                     sd_vld_o,
  output logic                     busy_o,
  output logic                     trig_o,
  output logic [$clog2(DEPTH)-1:0] trig_idx_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO + 1);

  localparam logic [AW:0]   ARM_CNT   = (AW+1)'(DEPTH - POST - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST - 1);
  localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARST  = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_cnt_q, post_q, trig_idx_q;
  logic [AW:0]   cnt_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    sd_q;
  logic          adc_req_q, adc_rst_q, sd_vld_q, busy_q, trig_q, done_q, err_q;
  logic [7:0]    mem_q [DEPTH];

  logic store, armed, hit, rd_fire;

  assign store   = (state_q == S_STORE) && !stop_i;
  assign armed   = (cnt_q == ARM_CNT);
  assign hit     = store && !trig_q && armed && (adc_dat_i > trd_i);
  assign rd_fire = (state_q == S_DONE) && rd_i && !start_i && !stop_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && !stop_i) state_d = S_ARST;
      S_ARST:  state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (adc_rdy_i)              state_d = S_STORE;
        else if (tmo_q == TMO_LAST) state_d = S_ERR;
      end
      S_STORE: state_d = (trig_q && post_q == POST_LAST) ? S_DONE : S_REQ;
      S_DONE: begin
        if (start_i)                           state_d = S_ARST;
        else if (rd_i && rd_cnt_q == RD_LAST)  state_d = S_IDLE;
      end
      S_ERR:   if (start_i) state_d = S_ARST;
      default: state_d = S_IDLE;
    endcase
    if (stop_i && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= adc_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      post_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      trig_idx_q <= '0;
      sd_q       <= '0;
      adc_req_q  <= 1'b0;
      adc_rst_q  <= 1'b0;
      sd_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      adc_rst_q <= (state_d == S_ARST);
      adc_req_q <= (state_d == S_REQ);
      busy_q    <= (state_d == S_ARST) || (state_d == S_REQ) ||
                   (state_d == S_WAIT) || (state_d == S_STORE);
      done_q    <= (state_d == S_DONE);
      err_q     <= (state_d == S_ERR);
      tmo_q     <= (state_q == S_WAIT) ? tmo_q + 1'b1 : '0;

      sd_vld_q <= rd_fire;
      if (rd_fire) begin
        sd_q     <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end

      if (store) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (!armed) cnt_q  <= cnt_q + 1'b1;
        if (trig_q) post_q <= post_q + 1'b1;
      end

      // Entry into DONE only comes from STORE, so the oldest sample sits one past wr_ptr.
      if (state_d == S_DONE && state_q != S_DONE) begin
        rd_ptr_q <= wr_ptr_q + 1'b1;
        rd_cnt_q <= '0;
      end

      if (state_q == S_IDLE || state_d == S_ARST) begin
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        post_q   <= '0;
      end

      if (state_d == S_IDLE || state_d == S_ARST) begin
        trig_q <= 1'b0;
      end else if (hit) begin
        trig_q     <= 1'b1;
        trig_idx_q <= wr_ptr_q;
      end
    end
  end

  assign adc_req_o  = adc_req_q;
  assign adc_rst_o  = adc_rst_q;
  assign sd_o       = sd_q;
  assign sd_vld_o   = sd_vld_q;
  assign busy_o     = busy_q;
  assign trig_o     = trig_q;
  assign trig_idx_o = trig_idx_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

`default_nettype wire
